// File: rtl/show_2c_arbiter.sv
// show_2c_arbiter: shares one combinational show_2c converter among N_REQ requesters, latching each result for DWELL cycles.
// Define SHOW2C_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index always wins.
module show_2c (
    input  logic [7:0]  din_i,
    output logic [15:0] dout_o,
    output logic        sign_o
);
    logic [7:0]  mag;
    logic [15:0] m, h, t, o;
    // Magnitude as three BCD digits; -128 maps to 128.
    always_comb begin
        mag    = din_i[7] ? 8'(-din_i) : din_i;
        m      = {8'h00, mag};
        h      = m / 16'd100;
        t      = (m % 16'd100) / 16'd10;
        o      = m % 16'd10;
        dout_o = (h << 8) | (t << 4) | o;
        sign_o = din_i[7];
    end
endmodule

module show_2c_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] din_bus_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               done_o,
    output logic [7:0]         conv_din_o,
    input  logic [15:0]        conv_dout_i,
    input  logic               conv_sign_i,
    output logic [15:0]        disp_val_o,
    output logic               disp_sign_o,
    output logic               disp_valid_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  grant_q;
    logic              done_q;
    logic [7:0]        conv_din_q;
    logic [15:0]       disp_val_q;
    logic              disp_sign_q;
    logic              disp_valid_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     win, idx;
    logic              hit;
`ifdef SHOW2C_ARB_RR_EN
    logic [PW-1:0]     ptr_q, win_q;
`endif

    always_comb begin
        win = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef SHOW2C_ARB_RR_EN
            idx = PW'((int'(ptr_q) + k) % N_REQ);
`else
            idx = PW'(k);
`endif
            if (!hit && req_i[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            done_q       <= 1'b0;
            conv_din_q   <= 8'h00;
            disp_val_q   <= 16'h0000;
            disp_sign_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            cnt_q        <= '0;
`ifdef SHOW2C_ARB_RR_EN
            ptr_q        <= '0;
            win_q        <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (|req_i) begin
                    conv_din_q <= din_bus_i[int'(win)*8 +: 8];
                    grant_q    <= N_REQ'(1) << win;
`ifdef SHOW2C_ARB_RR_EN
                    win_q      <= win;
`endif
                    state_q    <= CONV;
                end
                CONV: begin
                    disp_val_q   <= conv_dout_i;
                    disp_sign_q  <= conv_sign_i;
                    disp_valid_q <= 1'b1;
                    cnt_q        <= CW'(DWELL - 1);
                    state_q      <= HOLD;
                end
                HOLD: if (cnt_q == '0) begin
                    grant_q <= '0;
                    done_q  <= 1'b1;
`ifdef SHOW2C_ARB_RR_EN
                    ptr_q   <= (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
`endif
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign done_o       = done_q;
    assign conv_din_o   = conv_din_q;
    assign disp_val_o   = disp_val_q;
    assign disp_sign_o  = disp_sign_q;
    assign disp_valid_o = disp_valid_q;
endmodule
